seq_detect_scheduler: RTL
=========================

Name: seq_detect_scheduler

Overview:
- Time-multiplexes one consecutive-ones detector across NCH serial input channels.
- Holds a saturating run counter per channel and grants one requesting channel per cycle, round-robin.
- Pulses `out` with the channel id when that channel's run of 1s reaches the programmed length.
- Sits between the serial sources and the downstream event logic; replaces NCH separate consecutive-ones FSMs.

Parameters:
- NCH, 4, number of serial channels (power of 2, at least 2)
- CHW, 2, channel id width, equal to log2(NCH)
- CW, 3, run-counter and run-length width
- DEFAULT_LEN, 3, run length loaded at reset (1 to 2^CW-1)

Ports:
- clock, in, 1, rising-edge clock
- reset, in, 1, asynchronous active-low reset; 0 resets the block
- enable, in, 1, 1 = schedule channels (RUN); 0 = return to IDLE
- cfg_load, in, 1, load cfg_len; honoured in IDLE only
- cfg_len, in, CW, required run length
- req, in, NCH, per-channel "bit valid" request; held until acked
- bits, in, NCH, per-channel serial bit, valid while req[i]=1
- ack, out, NCH, one-hot grant, combinational; channel bit consumed at that clock edge
- out, out, 1, registered one-cycle detect pulse
- out_ch, out, CHW, registered channel id qualifying out
- busy, out, 1, registered, 1 while in RUN

Behaviour:
- **Reset (reset=0, async):**
  - state=IDLE, len_reg=DEFAULT_LEN, cnt[all]=0, ptr=NCH-1 (so ch0 wins first).
  - out=0, out_ch=0, busy=0.
  - ack=0 while reset is low.
- **States:** IDLE and RUN.
  - IDLE -> RUN on an edge with enable=1.
  - RUN -> IDLE on an edge with enable=0.
  - busy reflects the registered state.
- **Config:**
  - In IDLE with cfg_load=1: len_reg <= cfg_len, and all cnt <= 0.
  - cfg_len=0 is clamped to 1.
  - cfg_load in RUN is ignored; len_reg and cnt are unchanged.
  - cfg_load=1 and enable=1 in the same IDLE cycle: load takes effect and the state moves to RUN; the first grant uses the new length.
- **Grant:**
  - ack is nonzero only when state==RUN, enable==1 and req!=0.
  - Winner g is the first i with req[i]=1, searching ptr+1, ptr+2, ... modulo NCH.
  - ack = one-hot(g). On the edge, ptr <= g.
  - No grant means ptr is unchanged.
  - Exactly one grant per cycle at most. A channel with req held high is re-granted only after every other requester has been served.
- **Count update (granted channel g only; others hold):**
  - bits[g]=1: cnt[g] <= min(cnt[g]+1, len_reg), saturating.
  - bits[g]=0: cnt[g] <= 0.
- **Detect:**
  - out <= 1 and out_ch <= g at the grant edge iff bits[g]=1 and the updated count equals len_reg.
  - Latency is 1 cycle: out is visible the cycle after ack[g]=1.
  - While saturated, every further granted 1 re-pulses out. Any 0 re-arms the channel.
  - out_ch holds its last value when out=0.
- **enable drops in RUN:**
  - No grant is issued that cycle (ack=0).
  - The state moves to IDLE; counts and ptr are preserved.
  - Re-entering RUN resumes runs mid-sequence.
- **reset mid-run:** all state is cleared immediately and any pending detect is lost.
- **Width rule:** the count never exceeds len_reg, so there is no CW overflow.

Test Plan:
- **Reset defaults:** reset=0 for 2 cycles, then 1; enable=1, req=4'b0001, bits[0]=1 for 3 grants -> out=1, out_ch=0 exactly one cycle after the third ack; a 4th consecutive 1 -> out=1 again.
- **Round-robin fairness:** req=4'b1011 held, all bits=0 -> ack sequence 0001, 0010, 1000, 0001, ...; ch2 never acked; out stays 0.
- **Interleaved runs:** req=4'b0011, bits[0]=1, bits[1]=1 -> acks alternate; out pulses ch0 then ch1 on their 3rd grants (cycles 5 and 6 after enable).
- **Run broken by a zero:** ch0 bits 1,1,0,1,1,1 -> a single out pulse, on the 6th grant.
- **Config:**
  - In IDLE, cfg_load=1 with cfg_len=5 -> detect only on the 5th consecutive 1.
  - In IDLE, cfg_len=0 -> every granted 1 pulses out.
  - cfg_load in RUN with cfg_len=1 -> no change; detect stays on the 3rd 1.
- **Pause and resume:** ch0 gets 2 ones; enable=0 for 4 cycles (ack=0, busy=0); enable=1 and one more 1 -> out=1, out_ch=0. Async reset asserted between grants -> out=0 immediately and the count restarts from 0.

Source files
------------

// File: rtl/seq_detect_scheduler_if.sv
// Channel-side bundle of the detect scheduler: per-channel request/bit inputs,
// one-hot grant back to the sources, and the registered detect event.
interface seq_detect_scheduler_if #(
    parameter int NCH = 4,
    parameter int CHW = 2
);
    logic [NCH-1:0] req;
    logic [NCH-1:0] bits;
    logic [NCH-1:0] ack;
    logic           out;
    logic [CHW-1:0] out_ch;

    modport master (output req, output bits, input ack, input out, input out_ch);
    modport slave  (input req, input bits, output ack, output out, output out_ch);
endinterface

// File: rtl/seq_detect_scheduler.sv
// One shared consecutive-ones detector serving NCH serial channels, granting
// one requester per cycle in round-robin order with a saturating run count each.
module seq_detect_scheduler #(
    parameter int             NCH         = 4,
    parameter int             CHW         = 2,
    parameter int             CW          = 3,
    parameter logic [CW-1:0]  DEFAULT_LEN = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          cfg_load,
    input  logic [CW-1:0] cfg_len,
    output logic          busy,
    seq_detect_scheduler_if.slave sif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]     state_reg;
    logic [0:0]     state_next;
    logic [CW-1:0]  len_reg;
    logic [CW-1:0]  cnt_reg [NCH];
    logic [CHW-1:0] ptr_reg;
    logic           out_reg;
    logic [CHW-1:0] out_ch_reg;

    logic [CHW-1:0] cand;
    logic [CHW-1:0] grant_idx;
    logic           grant_any;
    logic           grant_vld;
    logic           bit_sel;
    logic [CW-1:0]  cnt_sel;
    logic [CW-1:0]  cnt_next;
    logic           hit;
    logic           cfg_apply;
    logic [CW-1:0]  len_eff;

    // Search starts just after the last winner; k == NCH wraps back onto ptr
    // itself so a lone requester is still found.
    always_comb begin
        cand      = '0;
        grant_idx = ptr_reg;
        grant_any = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            cand = ptr_reg + CHW'(k);
            if (!grant_any && sif.req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_vld = grant_any && (state_reg == RUN) && enable;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ack
        assign sif.ack[gi] = grant_vld && (grant_idx == CHW'(gi));
    end

    // Count never exceeds len_reg, so the +1 cannot wrap.
    always_comb begin
        bit_sel  = sif.bits[grant_idx];
        cnt_sel  = cnt_reg[grant_idx];
        cnt_next = '0;
        if (bit_sel) begin
            cnt_next = (cnt_sel >= len_reg) ? len_reg : cnt_sel + CW'(1);
        end
        hit = grant_vld && bit_sel && (cnt_next == len_reg);
    end

    assign cfg_apply  = (state_reg == IDLE) && cfg_load;
    assign len_eff    = (cfg_len == '0) ? CW'(1) : cfg_len;
    assign state_next = enable ? RUN : IDLE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            len_reg    <= DEFAULT_LEN;
            ptr_reg    <= CHW'(NCH - 1);
            out_reg    <= 1'b0;
            out_ch_reg <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            out_reg   <= hit;
            if (hit) begin
                out_ch_reg <= grant_idx;
            end
            if (grant_vld) begin
                ptr_reg <= grant_idx;
            end
            if (cfg_apply) begin
                len_reg <= len_eff;
                for (int i = 0; i < NCH; i++) begin
                    cnt_reg[i] <= '0;
                end
            end else if (grant_vld) begin
                cnt_reg[grant_idx] <= cnt_next;
            end
        end
    end

    assign busy       = (state_reg == RUN);
    assign sif.out    = out_reg;
    assign sif.out_ch = out_ch_reg;
endmodule
